imm_gen_pipe: RTL and testbench
===============================

IMM_GEN_PIPE -- requirements
Module: imm_gen_pipe

Interface
REQ-001 The block SHALL have parameter XLEN, default 32, output datapath width; legal values 32 and 64 only.
REQ-002 The block SHALL have parameter TAG_W, default 4, width of the sideband tag carried with each request.
REQ-003 The block SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset  input  1  reset, synchronous, active-high.
REQ-005 The block SHALL have port IR  input  32  instruction word.
REQ-006 The block SHALL have port ExtendSign  input  3  immediate format select.
REQ-007 The block SHALL have port in_tag  input  TAG_W  request tag.
REQ-008 The block SHALL have port in_valid  input  1  request valid.
REQ-009 The block SHALL have port in_ready  output  1  block can accept a request.
REQ-010 The block SHALL have port out  output  XLEN  extended immediate.
REQ-011 The block SHALL have port out_tag  output  TAG_W  tag of the result on out.
REQ-012 The block SHALL have port out_err  output  1  result came from an illegal format.
REQ-013 The block SHALL have port out_valid  output  1  result valid.
REQ-014 The block SHALL have port out_ready  input  1  consumer accepts the result.

Function
REQ-015 The block SHALL decode ExtendSign as: 000 I = sext(IR[31:20]); 001 S = sext({IR[31:25],IR[11:7]}); 010 B = sext({IR[31],IR[7],IR[30:25],IR[11:8],0}); 011 U = sext({IR[31:12],12'b0}); 100 J = sext({IR[31],IR[19:12],IR[20],IR[30:21],0}); 101 SHAMT = zext(IR[24:20]) at XLEN=32, zext(IR[25:20]) at XLEN=64; 110 ZIMM = zext(IR[19:15]); 111 illegal.
REQ-016 The block SHALL sign-extend using IR[31] as the sign source and SHALL zero-extend to exactly XLEN bits.
REQ-017 For an illegal format the block SHALL produce out = 0 and out_err = 1; for all legal formats out_err = 0.
REQ-018 The block SHALL accept a request on a cycle where in_valid and in_ready are both 1, and SHALL transfer a result on a cycle where out_valid and out_ready are both 1.
REQ-019 The block SHALL hold two entries, an output register and a skid register, tracked by the states EMPTY, ONE and TWO.
REQ-020 In EMPTY the block SHALL go to ONE on an accept; otherwise it SHALL stay in EMPTY.
REQ-021 In ONE the block SHALL stay in ONE on an accept with a simultaneous transfer, go to TWO on an accept without a transfer, and go to EMPTY on a transfer without an accept.
REQ-022 In TWO the block SHALL go to ONE on a transfer, moving the skid entry into the output register; otherwise it SHALL stay in TWO.
REQ-023 The block SHALL register in_ready, driving it to 1 in EMPTY and ONE and to 0 in TWO; an accept is therefore impossible in TWO.
REQ-024 Latency from accept to out_valid SHALL be exactly 1 cycle when the block is EMPTY, or ONE with a simultaneous transfer.
REQ-025 Sustained throughput SHALL be one result per cycle while out_ready = 1.
REQ-026 Results SHALL leave in acceptance order, and out, out_tag and out_err SHALL stay stable while out_valid = 1 and out_ready = 0.
REQ-027 out_valid SHALL be 1 exactly in states ONE and TWO.

Reset
REQ-028 When reset = 1 at a clock edge, the block SHALL enter EMPTY and drive out_valid = 0, in_ready = 1, out = 0, out_tag = 0 and out_err = 0 after that edge.
REQ-029 Reset SHALL override any simultaneous accept or transfer, and entries held at reset SHALL be discarded without being presented.
REQ-030 The block SHALL present in_ready = 1 on the first cycle after reset deasserts.

Configuration
REQ-031 With macro IMM_GEN_PIPE_ERRCNT_EN defined, the block SHALL add output err_count, 8 bits, which increments on each transfer with out_err = 1, saturates at 255 and resets to 0.
REQ-032 Without IMM_GEN_PIPE_ERRCNT_EN, the err_count port and its logic SHALL be absent, with all other behaviour unchanged.

Verification
REQ-033 Decode at XLEN=32, one per cycle with out_ready=1: FFF00093/I -> FFFFFFFF; FE20AE23/S -> FFFFFFFC; FE000CE3/B -> FFFFFFF8; 123450B7/U -> 12345000; 008000EF/J -> 00000008; each SHALL appear 1 cycle after its accept.
REQ-034 At XLEN=64: FE000CE3/B -> FFFFFFFFFFFFFFF8; 02A00013/SHAMT -> 000000000000002A.
REQ-035 Backpressure: out_ready=0 with in_valid=1 tags 1,2,3 -> tags 1 and 2 accepted, in_ready=0 the following cycle; then out_ready=1 -> tags 1,2,3 emitted in order, no loss or duplication.
REQ-036 Illegal: ExtendSign=111, IR=FFFFFFFF -> out=0, out_err=1; with IMM_GEN_PIPE_ERRCNT_EN, 300 illegal transfers -> err_count=255.
REQ-037 Reset mid-operation: state TWO, reset for 1 cycle -> out_valid=0, in_ready=1 and out=0 on the next cycle; the held entries SHALL never appear.

Source files
------------

// File: rtl/imm_gen_pipe.sv
// Immediate generator with a two-entry (output + skid) elastic stage.
// Optional 8-bit illegal-format counter on err_count when IMM_GEN_PIPE_ERRCNT_EN is defined.
module imm_gen_pipe #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      IR,
    input  logic [2:0]       ExtendSign,
    input  logic [TAG_W-1:0] in_tag,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [XLEN-1:0]  out,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_err,
    output logic             out_valid,
    input  logic             out_ready
`ifdef IMM_GEN_PIPE_ERRCNT_EN
    ,
    output logic [7:0]       err_count
`endif
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    state_t state, state_nx;

    logic [31:0]      raw;
    logic [XLEN-1:0]  dec_imm;
    logic             dec_err;
    logic [XLEN-1:0]  skid_imm;
    logic [TAG_W-1:0] skid_tag;
    logic             skid_err;
    logic             accept, xfer;
    logic             load_out, load_skid, skid_to_out;
    logic             unused_opcode;

    assign unused_opcode = ^IR[6:0];

    // Every format is first formed as a 32-bit value whose bit 31 is the
    // intended extension bit (zero for SHAMT/ZIMM), so one signed widen covers all.
    always_comb begin
        raw     = '0;
        dec_err = 1'b0;
        case (ExtendSign)
            3'b000: raw = {{20{IR[31]}}, IR[31:20]};
            3'b001: raw = {{20{IR[31]}}, IR[31:25], IR[11:7]};
            3'b010: raw = {{19{IR[31]}}, IR[31], IR[7], IR[30:25], IR[11:8], 1'b0};
            3'b011: raw = {IR[31:12], 12'b0};
            3'b100: raw = {{11{IR[31]}}, IR[31], IR[19:12], IR[20], IR[30:21], 1'b0};
            3'b101: raw = {26'b0, (XLEN == 64) ? IR[25] : 1'b0, IR[24:20]};
            3'b110: raw = {27'b0, IR[19:15]};
            default: begin
                raw     = '0;
                dec_err = 1'b1;
            end
        endcase
    end

    assign dec_imm   = XLEN'(signed'(raw));
    assign out_valid = (state != EMPTY);
    assign accept    = in_valid && in_ready;
    assign xfer      = out_valid && out_ready;

    always_comb begin
        state_nx    = state;
        load_out    = 1'b0;
        load_skid   = 1'b0;
        skid_to_out = 1'b0;
        case (state)
            EMPTY: begin
                if (accept) begin
                    state_nx = ONE;
                    load_out = 1'b1;
                end
            end
            ONE: begin
                if (accept && xfer) begin
                    load_out = 1'b1;
                end else if (accept) begin
                    state_nx  = TWO;
                    load_skid = 1'b1;
                end else if (xfer) begin
                    state_nx = EMPTY;
                end
            end
            TWO: begin
                if (xfer) begin
                    state_nx    = ONE;
                    skid_to_out = 1'b1;
                end
            end
            default: state_nx = EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= EMPTY;
            in_ready <= 1'b1;
            out      <= '0;
            out_tag  <= '0;
            out_err  <= 1'b0;
            skid_imm <= '0;
            skid_tag <= '0;
            skid_err <= 1'b0;
        end else begin
            state    <= state_nx;
            in_ready <= (state_nx != TWO);
            if (load_out) begin
                out     <= dec_imm;
                out_tag <= in_tag;
                out_err <= dec_err;
            end else if (skid_to_out) begin
                out     <= skid_imm;
                out_tag <= skid_tag;
                out_err <= skid_err;
            end
            if (load_skid) begin
                skid_imm <= dec_imm;
                skid_tag <= in_tag;
                skid_err <= dec_err;
            end
        end
    end

`ifdef IMM_GEN_PIPE_ERRCNT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            err_count <= '0;
        end else if (xfer && out_err && (err_count != 8'hFF)) begin
            err_count <= err_count + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Directed self-checking bench for imm_gen_pipe; drives an XLEN=32 and an XLEN=64
// instance with the same stimulus (err_count checked when IMM_GEN_PIPE_ERRCNT_EN is defined).
module tb_imm_gen_pipe;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] IR;
    logic [2:0]  ExtendSign;
    logic [3:0]  in_tag;
    logic        in_valid;
    logic        out_ready;

    logic        in_ready32, out_err32, out_valid32;
    logic [31:0] out32;
    logic [3:0]  out_tag32;
    logic        in_ready64, out_err64, out_valid64;
    logic [63:0] out64;
    logic [3:0]  out_tag64;
`ifdef IMM_GEN_PIPE_ERRCNT_EN
    logic [7:0]  err_count32, err_count64;
`endif

    int unsigned passes = 0;
    int unsigned total  = 0;

    always #5 clk = ~clk;

    imm_gen_pipe #(.XLEN(32), .TAG_W(4)) u_dut32 (
        .clk(clk), .reset(reset), .IR(IR), .ExtendSign(ExtendSign),
        .in_tag(in_tag), .in_valid(in_valid), .in_ready(in_ready32),
        .out(out32), .out_tag(out_tag32), .out_err(out_err32),
        .out_valid(out_valid32), .out_ready(out_ready)
`ifdef IMM_GEN_PIPE_ERRCNT_EN
        , .err_count(err_count32)
`endif
    );

    imm_gen_pipe #(.XLEN(64), .TAG_W(4)) u_dut64 (
        .clk(clk), .reset(reset), .IR(IR), .ExtendSign(ExtendSign),
        .in_tag(in_tag), .in_valid(in_valid), .in_ready(in_ready64),
        .out(out64), .out_tag(out_tag64), .out_err(out_err64),
        .out_valid(out_valid64), .out_ready(out_ready)
`ifdef IMM_GEN_PIPE_ERRCNT_EN
        , .err_count(err_count64)
`endif
    );

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %h expected %h", name, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] ir, input logic [2:0] es, input logic [3:0] tag);
        IR         = ir;
        ExtendSign = es;
        in_tag     = tag;
        in_valid   = 1'b1;
    endtask

    initial begin
        reset = 1'b1; IR = '0; ExtendSign = '0; in_tag = '0;
        in_valid = 1'b0; out_ready = 1'b1;
        tick(); tick();
        chk("rst_out_valid", 64'(out_valid32), 64'd0);
        chk("rst_in_ready",  64'(in_ready32),  64'd1);
        chk("rst_out",       64'(out32),       64'd0);
        chk("rst_out_tag",   64'(out_tag32),   64'd0);
        chk("rst_out_err",   64'(out_err32),   64'd0);
        reset = 1'b0;
        tick();
        chk("post_rst_in_ready", 64'(in_ready32), 64'd1);

        // one decode per cycle, result one cycle after accept
        drive(32'hFFF00093, 3'b000, 4'd1); tick();
        chk("I_out", 64'(out32), 64'hFFFFFFFF);
        chk("I_valid", 64'(out_valid32), 64'd1);
        chk("I_tag", 64'(out_tag32), 64'd1);
        drive(32'hFE20AE23, 3'b001, 4'd2); tick();
        chk("S_out", 64'(out32), 64'hFFFFFFFC);
        chk("S_tag", 64'(out_tag32), 64'd2);
        drive(32'hFE000CE3, 3'b010, 4'd3); tick();
        chk("B_out", 64'(out32), 64'hFFFFFFF8);
        chk("B_out64", out64, 64'hFFFFFFFFFFFFFFF8);
        drive(32'h123450B7, 3'b011, 4'd4); tick();
        chk("U_out", 64'(out32), 64'h12345000);
        chk("U_out64", out64, 64'h0000000012345000);
        drive(32'h008000EF, 3'b100, 4'd5); tick();
        chk("J_out", 64'(out32), 64'h00000008);
        drive(32'h02A00013, 3'b101, 4'd6); tick();
        chk("SHAMT_out32", 64'(out32), 64'h0000000A);
        chk("SHAMT_out64", out64, 64'h000000000000002A);
        drive(32'h800F8000, 3'b110, 4'd7); tick();
        chk("ZIMM_out", 64'(out32), 64'h0000001F);
        chk("ZIMM_out64", out64, 64'h000000000000001F);
        chk("ZIMM_err", 64'(out_err32), 64'd0);
        drive(32'hFFFFFFFF, 3'b111, 4'd8); tick();
        chk("ILL_out", 64'(out32), 64'd0);
        chk("ILL_err", 64'(out_err32), 64'd1);
        chk("ILL_out64", out64, 64'd0);
        chk("ILL_in_ready", 64'(in_ready32), 64'd1);
        in_valid = 1'b0; tick();
        chk("drain_valid", 64'(out_valid32), 64'd0);

        // backpressure: I-type with imm = tag so out identifies the entry
        out_ready = 1'b0;
        drive(32'h00100013, 3'b000, 4'd1); tick();
        chk("bp1_tag", 64'(out_tag32), 64'd1);
        chk("bp1_in_ready", 64'(in_ready32), 64'd1);
        drive(32'h00200013, 3'b000, 4'd2); tick();
        chk("bp2_in_ready", 64'(in_ready32), 64'd0);
        chk("bp2_tag", 64'(out_tag32), 64'd1);
        drive(32'h00300013, 3'b000, 4'd3); tick();
        chk("bp3_in_ready", 64'(in_ready32), 64'd0);
        chk("bp3_hold_tag", 64'(out_tag32), 64'd1);
        chk("bp3_hold_out", 64'(out32), 64'd1);
        out_ready = 1'b1; tick();
        chk("bp4_tag", 64'(out_tag32), 64'd2);
        chk("bp4_out", 64'(out32), 64'd2);
        chk("bp4_in_ready", 64'(in_ready32), 64'd1);
        tick();
        chk("bp5_tag", 64'(out_tag32), 64'd3);
        chk("bp5_out", 64'(out32), 64'd3);
        in_valid = 1'b0; tick();
        chk("bp6_empty", 64'(out_valid32), 64'd0);

        // reset while holding two entries
        out_ready = 1'b0;
        drive(32'h00400013, 3'b000, 4'd4); tick();
        drive(32'h00500013, 3'b000, 4'd5); tick();
        chk("two_in_ready", 64'(in_ready32), 64'd0);
        in_valid = 1'b0; reset = 1'b1; tick();
        chk("mrst_valid", 64'(out_valid32), 64'd0);
        chk("mrst_in_ready", 64'(in_ready32), 64'd1);
        chk("mrst_out", 64'(out32), 64'd0);
        chk("mrst_tag", 64'(out_tag32), 64'd0);
        reset = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("mrst_no_ghost", 64'(out_valid32), 64'd0);
        end

`ifdef IMM_GEN_PIPE_ERRCNT_EN
        chk("errcnt_reset", 64'(err_count32), 64'd0);
        drive(32'hFFFFFFFF, 3'b111, 4'd9);
        for (int i = 0; i < 300; i++) tick();
        in_valid = 1'b0; tick();
        chk("errcnt_sat32", 64'(err_count32), 64'd255);
        chk("errcnt_sat64", 64'(err_count64), 64'd255);
`endif

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
